cmp_share_sched: RTL and testbench
==================================

# cmp_share_sched

Round-robin scheduler that shares one 16-bit unsigned comparator (`out = 1` when `in0 <= in1`, `0` when `in0 > in1`) among several requesters in the morphing-wing peripheral. The block accepts compare requests, drives the shared comparator's operand inputs from registers, and samples its result. It then returns a tagged result to the requester through a valid/ready handshake. The comparator instance stays outside this block and is purely combinational.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 16, operand width; must match the shared comparator
- `IDW`, `$clog2(NREQ)`, width of the requester ID (localparam)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req`  in  NREQ  per-requester compare request, level, held until granted
- `req_a`  in  NREQ*WIDTH  operand A; requester i uses bits `[i*WIDTH +: WIDTH]`
- `req_b`  in  NREQ*WIDTH  operand B, same packing as `req_a`
- `gnt`  out  NREQ  one-hot, one-cycle pulse; requester i's operands were captured
- `cmp_in0`  out  WIDTH  to the shared comparator `in0`; registered operand A
- `cmp_in1`  out  WIDTH  to the shared comparator `in1`; registered operand B
- `cmp_out`  in  1  from the shared comparator `out`
- `rsp_valid`  out  1  result available
- `rsp_id`  out  IDW  index of the requester that owns the result
- `rsp_le`  out  1  registered `cmp_out`: 1 means A <= B (unsigned)
- `rsp_ready`  in  1  consumer accepts the result
- `busy`  out  1  high in every state other than IDLE

## Operation
- **FSM states:** IDLE, CMP, RESP.
- **IDLE:**
  - If `req` is nonzero, choose the winner: the first set bit, scanning from index `last+1` upward, modulo NREQ.
  - Load `cmp_in0`/`cmp_in1` with the winner's `req_a`/`req_b`.
  - Set `gnt[winner]`, `last` ← winner, `rsp_id` ← winner, and go to CMP.
  - If `req` is zero, stay in IDLE.
- **CMP:**
  - The operands are stable on the comparator for this whole cycle.
  - At the edge that ends CMP: `rsp_le` ← `cmp_out`, `rsp_valid` ← 1, go to RESP.
- **RESP:**
  - Hold `rsp_valid`, `rsp_id` and `rsp_le` stable.
  - When `rsp_ready` is sampled high: `rsp_valid` ← 0, go to IDLE.
  - `req` is ignored in RESP.
- **`gnt`:** registered. It is high only during the single cycle after the capture edge and is cleared at the next edge.
- **Requester obligation:** drop or change `req[i]` only after seeing `gnt[i]`. The block never samples `req` before returning to IDLE, so requester i cannot be granted twice for one request.
- **Operand registers:** `cmp_in0`/`cmp_in1` keep the last captured operands and are not cleared after use.
- **Arithmetic:** comparison is unsigned over the full WIDTH. No sign or width extension.
- **Reset values:**
  - State IDLE; `last` = NREQ-1, so requester 0 has top priority after reset.
  - `gnt`, `cmp_in0`, `cmp_in1`, `rsp_valid`, `rsp_id`, `rsp_le` and `busy` are all 0.
- **Reset mid-operation:** everything clears immediately, including `rsp_valid`. The in-flight request produces no response and is not retried by the block; the requester must still be holding `req` to be served.
- **Simultaneous requests:** exactly one grant per transaction, in round-robin order. A continuously asserted requester waits at most NREQ-1 transactions.
- **Combinational paths:** none from inputs to outputs; every output is a flop.

## Timing
- **Latency:**
  - Edge E0 (IDLE with `req` ≠ 0): capture.
  - Cycle after E0: `gnt` high.
  - Edge E1: `rsp_valid` rises.
  - The earliest `rsp_ready` acceptance is edge E2; the FSM is back in IDLE after E2.
- **Throughput:** at most one compare per 3 cycles; the next capture is at E3 at the earliest.
- **Backpressure:** each cycle `rsp_ready` is low adds one cycle in RESP.
- **`cmp_out` sampling:** sampled exactly one cycle after `cmp_in0`/`cmp_in1` change. The shared comparator must settle within one `clk` period.
- **Handshake:** `rsp_valid` is never deasserted without an accepting `rsp_ready`, except by reset.

## Test plan
1. Only `req[1]`, a=0x1234, b=0x1234 -> `gnt`=0010 for one cycle after E0; at E1 `rsp_valid`=1, `rsp_id`=1, `rsp_le`=1; with `rsp_ready`=1, back in IDLE after E2.
2. Unsigned extremes via `req[0]`: a=0x8000, b=0x7FFF -> `rsp_le`=0; then a=0x0000, b=0xFFFF -> `rsp_le`=1; then a=0xFFFF, b=0xFFFF -> `rsp_le`=1.
3. All four `req` held high, each requester releasing after its `gnt`, then re-asserting -> grant order 0,1,2,3,0,1; results are 3 cycles apart with `rsp_ready` tied high.
4. After a grant to requester 3, assert `req`=1001 -> requester 0 granted next (wrap-around), then 3.
5. `rsp_ready`=0 for 5 cycles while `req[2]` is pending -> `rsp_valid`, `rsp_id`, `rsp_le` stable and no `gnt` for those 5 cycles; `gnt[2]` pulses 2 cycles after `rsp_ready` rises.
6. Assert `rst_n`=0 during CMP for requester 2 -> all outputs 0 asynchronously, no response; after release with `req`=0110, requester 1 is granted first.

Source files
------------

// File: rtl/cmp_share_sched.sv
// cmp_share_sched: round-robin scheduler that time-shares one external
// combinational 16-bit unsigned comparator among NREQ requesters.
// A request is captured into the operand registers (IDLE), the comparator
// settles for one full cycle (CMP), and the sampled result is returned with
// a valid/ready handshake (RESP).
module cmp_share_sched #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 16,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      cmp_in0,
    output logic [WIDTH-1:0]      cmp_in1,
    input  logic                  cmp_out,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_le,
    input  logic                  rsp_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] last;       // most recently granted requester
    logic [IDW-1:0] winner;     // round-robin pick among current requests
    logic [IDW-1:0] idx;        // scan position inside the pick loop
    logic           capture;    // IDLE with a pending request
    logic           finish;     // last cycle of CMP: sample comparator
    logic           accept;     // RESP handshake completes

    // Round-robin pick: first set req bit scanning upward from last+1.
    // Scanning the offsets in descending order lets the nearest one win
    // without an early exit from the loop.
    always_comb begin
        winner = last;
        idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (req[idx]) winner = idx;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        capture   = 1'b0;
        finish    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    capture   = 1'b1;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                finish    = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand registers are reset too: they drive a port
            // directly and must read as zero out of reset.
            gnt       <= '0;
            cmp_in0   <= '0;
            cmp_in1   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_le    <= 1'b0;
            busy      <= 1'b0;
            last      <= IDW'(NREQ - 1);
        end else begin
            gnt  <= '0;
            busy <= (state_nxt != IDLE);
            if (capture) begin
                cmp_in0     <= req_a[int'(winner)*WIDTH +: WIDTH];
                cmp_in1     <= req_b[int'(winner)*WIDTH +: WIDTH];
                gnt[winner] <= 1'b1;
                last        <= winner;
                rsp_id      <= winner;
            end
            if (finish) begin
                rsp_le    <= cmp_out;
                rsp_valid <= 1'b1;
            end
            if (accept) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmp_share_sched.sv
// tb_cmp_share_sched: directed bench for cmp_share_sched with a behavioural
// model of the shared comparator and hand-computed expected values.
module tb_cmp_share_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      cmp_in0;
    logic [WIDTH-1:0]      cmp_in1;
    logic                  cmp_out;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_le;
    logic                  rsp_ready;
    logic                  busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    cmp_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .cmp_in0   (cmp_in0),
        .cmp_in1   (cmp_in1),
        .cmp_out   (cmp_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_le    (rsp_le),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // External shared comparator: purely combinational unsigned <=.
    assign cmp_out = (cmp_in0 <= cmp_in1);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req       = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        #12;
        total++;
        if ({gnt, cmp_in0, cmp_in1, rsp_valid, rsp_id, rsp_le, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b in0=%h in1=%h v=%b id=%0d le=%b busy=%b want all 0",
                     gnt, cmp_in0, cmp_in1, rsp_valid, rsp_id, rsp_le, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL idle_no_req: busy=%b gnt=%b want 0 0000", busy, gnt);
        end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        req_a[1*WIDTH +: WIDTH] = 16'h1234;
        req_b[1*WIDTH +: WIDTH] = 16'h1234;
        req = 4'b0010;
        step();  // E0
        total++;
        if (gnt !== 4'b0010 || cmp_in0 !== 16'h1234 || cmp_in1 !== 16'h1234 ||
            busy !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_capture: gnt=%b in0=%h in1=%h busy=%b v=%b want 0010 1234 1234 1 0",
                     gnt, cmp_in0, cmp_in1, busy, rsp_valid);
        end
        req = 4'b0000;
        step();  // E1
        total++;
        if (gnt !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_le !== 1'b1) begin
            bad++;
            $display("FAIL single_resp: gnt=%b v=%b id=%0d le=%b want 0000 1 1 1",
                     gnt, rsp_valid, rsp_id, rsp_le);
        end
        step();  // E2
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmp_in0 !== 16'h1234) begin
            bad++;
            $display("FAIL single_done: v=%b busy=%b in0=%h want 0 0 1234",
                     rsp_valid, busy, cmp_in0);
        end
    endtask

    task automatic test_extremes();
        logic [WIDTH-1:0] va [3] = '{16'h8000, 16'h0000, 16'hFFFF};
        logic [WIDTH-1:0] vb [3] = '{16'h7FFF, 16'hFFFF, 16'hFFFF};
        logic             vle[3] = '{1'b0, 1'b1, 1'b1};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_a[0 +: WIDTH] = va[i];
            req_b[0 +: WIDTH] = vb[i];
            req = 4'b0001;
            step();
            total++;
            if (gnt !== 4'b0001) begin
                bad++;
                $display("FAIL extreme%0d_gnt: got %b want 0001", i, gnt);
            end
            req = 4'b0000;
            step();
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_le !== vle[i]) begin
                bad++;
                $display("FAIL extreme%0d_le: v=%b id=%0d le=%b want 1 0 %b",
                         i, rsp_valid, rsp_id, rsp_le, vle[i]);
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        logic ele [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int prev_cyc;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = WIDTH'(i);
            req_b[i*WIDTH +: WIDTH] = 16'd2;
        end
        rsp_ready = 1'b1;
        req = 4'b1111;
        prev_cyc = 0;
        for (int t = 0; t < 6; t++) begin
            step();  // capture
            total++;
            if (gnt !== 4'(1 << order[t])) begin
                bad++;
                $display("FAIL rr%0d_gnt: got %b want %b", t, gnt, 4'(1 << order[t]));
            end
            req[order[t]] = 1'b0;
            step();  // result
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(order[t]) || rsp_le !== ele[t]) begin
                bad++;
                $display("FAIL rr%0d_resp: v=%b id=%0d le=%b want 1 %0d %b",
                         t, rsp_valid, rsp_id, rsp_le, order[t], ele[t]);
            end
            if (t > 0) begin
                total++;
                if (cyc - prev_cyc !== 3) begin
                    bad++;
                    $display("FAIL rr%0d_spacing: got %0d cycles want 3", t, cyc - prev_cyc);
                end
            end
            prev_cyc = cyc;
            req[order[t]] = 1'b1;
            step();  // accept
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_wrap();
        int order [3] = '{3, 0, 3};
        rsp_ready = 1'b1;
        req_a[3*WIDTH +: WIDTH] = 16'h0010;
        req_b[3*WIDTH +: WIDTH] = 16'h000F;
        req = 4'b1000;
        for (int t = 0; t < 3; t++) begin
            step();
            total++;
            if (gnt !== 4'(1 << order[t])) begin
                bad++;
                $display("FAIL wrap%0d_gnt: got %b want %b", t, gnt, 4'(1 << order[t]));
            end
            req[order[t]] = 1'b0;
            step();
            total++;
            if (rsp_id !== IDW'(order[t])) begin
                bad++;
                $display("FAIL wrap%0d_id: got %0d want %0d", t, rsp_id, order[t]);
            end
            step();
            if (t == 0) req = 4'b1001;
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req_a[0 +: WIDTH] = 16'd5;
        req_b[0 +: WIDTH] = 16'd3;
        req_a[2*WIDTH +: WIDTH] = 16'hABCD;
        req_b[2*WIDTH +: WIDTH] = 16'hABCE;
        req = 4'b0001;
        step();
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL bp_gnt0: got %b want 0001", gnt);
        end
        req = 4'b0100;
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_le !== 1'b0 ||
                gnt !== 4'b0000 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold%0d: v=%b id=%0d le=%b gnt=%b busy=%b want 1 0 0 0000 1",
                         c, rsp_valid, rsp_id, rsp_le, gnt, busy);
            end
        end
        rsp_ready = 1'b1;
        step();  // accept
        total++;
        if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL bp_accept: v=%b gnt=%b want 0 0000", rsp_valid, gnt);
        end
        step();  // capture requester 2
        total++;
        if (gnt !== 4'b0100 || cmp_in0 !== 16'hABCD) begin
            bad++;
            $display("FAIL bp_gnt2: gnt=%b in0=%h want 0100 abcd", gnt, cmp_in0);
        end
        req = 4'b0000;
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_le !== 1'b1) begin
            bad++;
            $display("FAIL bp_resp2: v=%b id=%0d le=%b want 1 2 1", rsp_valid, rsp_id, rsp_le);
        end
        step();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        req = 4'b0100;
        step();  // capture; FSM now in CMP
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL mid_gnt: got %b want 0100", gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({gnt, cmp_in0, cmp_in1, rsp_valid, rsp_id, rsp_le, busy} !== '0) begin
            bad++;
            $display("FAIL mid_async_clear: gnt=%b in0=%h in1=%h v=%b id=%0d le=%b busy=%b want all 0",
                     gnt, cmp_in0, cmp_in1, rsp_valid, rsp_id, rsp_le, busy);
        end
        req = 4'b0110;
        step();
        total++;
        if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL mid_in_reset: v=%b gnt=%b want 0 0000", rsp_valid, gnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (gnt !== 4'b0010 || rsp_id !== 2'd1) begin
            bad++;
            $display("FAIL mid_first_gnt: gnt=%b id=%0d want 0010 1", gnt, rsp_id);
        end
        req = 4'b0100;
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
            bad++;
            $display("FAIL mid_resp: v=%b id=%0d want 1 1", rsp_valid, rsp_id);
        end
        step();
        req = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
